// File: rtl/pcie2_x1_sync_arb_if.sv
// Bus bundle between the event sources / slow-domain synchronizer and pcie2_x1_sync_arb.
// slave = arbiter side, master = requesters plus synchronizer side.
interface pcie2_x1_sync_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0] req_pulse;
  logic [NUM_REQ-1:0] pend;
  logic               sync_req;
  logic [ID_W-1:0]    sync_id;
  logic               sync_ack;
  logic               busy;
  logic               done_pulse;
  logic [ID_W-1:0]    done_id;
  logic               timeout_err;

  modport slave (
    input  req_pulse, sync_ack,
    output pend, sync_req, sync_id, busy, done_pulse, done_id, timeout_err
  );

  modport master (
    output req_pulse, sync_ack,
    input  pend, sync_req, sync_id, busy, done_pulse, done_id, timeout_err
  );
endinterface

// File: rtl/pcie2_x1_sync_arb.sv
// Round-robin arbiter sharing one 4-phase req/ack synchronizer channel among NUM_REQ event sources.
// Optional handshake watchdog: define PCIE2_SYNC_ARB_TIMEOUT_EN.
module pcie2_x1_sync_arb #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                i_clk,
  input logic                i_rst,
  pcie2_x1_sync_arb_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("ID_W must equal clog2(NUM_REQ)");
  end
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("NUM_REQ out of range 2..16");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC out of range 1..65535");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_pend;
  logic [ID_W-1:0]    r_ptr;
  logic               r_sync_req;
  logic [ID_W-1:0]    r_sync_id;
  logic               r_busy;
  logic               r_done_pulse;
  logic [ID_W-1:0]    r_done_id;

  logic               w_found;
  logic [ID_W-1:0]    w_win;
  logic               w_grant;
  logic               w_sync_req_nxt;
  logic               w_done_nxt;
  logic               w_timeout_nxt;
  logic               w_cnt_hit;

  // Returns {found, index}: first pending bit at or above ptr, wrapping to 0.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!res[ID_W] && req[idx]) begin
        res = {1'b1, ID_W'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  always_comb begin
    {w_found, w_win} = rr_pick(r_pend, r_ptr);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant        = 1'b0;
    w_sync_req_nxt = r_sync_req;
    w_done_nxt     = 1'b0;
    w_timeout_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A still-high ack belongs to an aborted or stale handshake; never grant over it.
        if (w_found && !bus.sync_ack) begin
          w_grant        = 1'b1;
          w_sync_req_nxt = 1'b1;
          w_state_nxt    = ST_REQ;
        end else begin
          w_sync_req_nxt = 1'b0;
        end
      end
      ST_REQ: begin
        if (bus.sync_ack) begin
          w_sync_req_nxt = 1'b0;
          w_state_nxt    = ST_REL;
        end else if (w_cnt_hit) begin
          w_sync_req_nxt = 1'b0;
          w_timeout_nxt  = 1'b1;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_sync_req_nxt = 1'b1;
        end
      end
      ST_REL: begin
        if (!bus.sync_ack) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_cnt_hit) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_state_nxt = ST_REL;
        end
        w_sync_req_nxt = 1'b0;
      end
      default: begin
        w_sync_req_nxt = 1'b0;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_pend       <= {NUM_REQ{1'b0}};
      r_ptr        <= {ID_W{1'b0}};
      r_sync_req   <= 1'b0;
      r_sync_id    <= {ID_W{1'b0}};
      r_busy       <= 1'b0;
      r_done_pulse <= 1'b0;
      r_done_id    <= {ID_W{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_sync_req   <= w_sync_req_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_done_pulse <= w_done_nxt;
      // A new pulse on the granted bit is ORed in after the clear, so it survives.
      r_pend <= (r_pend & ~(w_grant ? (NUM_REQ'(1) << w_win) : {NUM_REQ{1'b0}}))
                | bus.req_pulse;
      if (w_grant) begin
        r_sync_id <= w_win;
        r_ptr     <= (w_win == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : w_win + 1'b1;
      end else begin
        r_sync_id <= r_sync_id;
        r_ptr     <= r_ptr;
      end
      if (w_done_nxt || w_timeout_nxt) begin
        r_done_id <= r_sync_id;
      end else begin
        r_done_id <= r_done_id;
      end
    end
  end

`ifdef PCIE2_SYNC_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_timeout_err;

  assign w_cnt_hit = (r_cnt == 16'(TIMEOUT_CYC - 1));

  // Phase watchdog: restarts on every entry into REQ or REL.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt         <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= 16'd0;
      end else if (r_state != ST_IDLE) begin
        r_cnt <= r_cnt + 16'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign w_cnt_hit       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.pend       = r_pend;
  assign bus.sync_req   = r_sync_req;
  assign bus.sync_id    = r_sync_id;
  assign bus.busy       = r_busy;
  assign bus.done_pulse = r_done_pulse;
  assign bus.done_id    = r_done_id;

endmodule

// File: tb/tb_pcie2_x1_sync_arb.sv
// Directed self-checking bench for pcie2_x1_sync_arb; the bench plays the slow-domain ack side.
// Define PCIE2_SYNC_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYC=8).
module tb_pcie2_x1_sync_arb;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pcie2_x1_sync_arb_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  pcie2_x1_sync_arb #(.NUM_REQ(4), .ID_W(2), .TIMEOUT_CYC(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the grant, then walks through one full handshake for exp_id.
  task automatic run_hs(input logic [1:0] exp_id);
    int n;
    n = 0;
    while (!bus.sync_req && n < 20) begin
      tick();
      n++;
    end
    chk_val("hs_req_seen", bus.sync_req, 1);
    chk_val("hs_id", bus.sync_id, exp_id);
    chk_val("hs_busy", bus.busy, 1);
    repeat (2) tick();
    chk_val("hs_req_hold", bus.sync_req, 1);
    bus.sync_ack = 1'b1;
    tick();
    chk_val("hs_req_drop", bus.sync_req, 0);
    chk_val("hs_no_early_done", bus.done_pulse, 0);
    repeat (2) tick();
    chk_val("hs_rel_busy", bus.busy, 1);
    bus.sync_ack = 1'b0;
    tick();
    chk_val("hs_done", bus.done_pulse, 1);
    chk_val("hs_done_id", bus.done_id, exp_id);
    chk_val("hs_no_timeout", bus.timeout_err, 0);
    chk_val("hs_idle", bus.busy, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.req_pulse = 4'b0000;
    bus.sync_ack  = 1'b0;
    #2;
    chk_val("rst_pend", bus.pend, 0);
    chk_val("rst_req", bus.sync_req, 0);
    chk_val("rst_id", bus.sync_id, 0);
    chk_val("rst_busy", bus.busy, 0);
    chk_val("rst_done", bus.done_pulse, 0);
    chk_val("rst_done_id", bus.done_id, 0);
    chk_val("rst_tmo", bus.timeout_err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // T1: single event on requester 2
    bus.req_pulse = 4'b0100;
    tick();
    bus.req_pulse = 4'b0000;
    chk_val("t1_pend_c1", bus.pend, 4'b0100);
    chk_val("t1_req_c1", bus.sync_req, 0);
    tick();
    chk_val("t1_req_c2", bus.sync_req, 1);
    chk_val("t1_id_c2", bus.sync_id, 2);
    chk_val("t1_pend_c2", bus.pend, 4'b0000);
    run_hs(2'd2);
    tick();
    chk_val("t1_done_one_cycle", bus.done_pulse, 0);
    chk_val("t1_pend_after", bus.pend, 0);
    chk_val("t1_id_held", bus.sync_id, 2);

    // T2: all four at once, ptr restarts search at 3 after T1 grant of 2
    bus.req_pulse = 4'b1111;
    tick();
    bus.req_pulse = 4'b0000;
    chk_val("t2_pend_all", bus.pend, 4'b1111);
    tick();
    chk_val("t2_first_id", bus.sync_id, 3);
    chk_val("t2_pend_minus3", bus.pend, 4'b0111);
    run_hs(2'd3);
    run_hs(2'd0);
    run_hs(2'd1);
    run_hs(2'd2);
    tick();
    chk_val("t2_pend_drained", bus.pend, 0);
    // ptr is now 3: pulse 4'b1111 again would start at 3, so use 4'b0011 -> wraps to 0 then 1
    bus.req_pulse = 4'b0011;
    tick();
    bus.req_pulse = 4'b0000;
    run_hs(2'd0);
    run_hs(2'd1);

    // T3: re-pulse of requester 1 in its own grant cycle is queued
    tick();
    bus.req_pulse = 4'b0010;
    tick();
    chk_val("t3_pend_set", bus.pend, 4'b0010);
    tick();
    bus.req_pulse = 4'b0000;
    chk_val("t3_grant", bus.sync_req, 1);
    chk_val("t3_grant_id", bus.sync_id, 1);
    chk_val("t3_pend_kept", bus.pend, 4'b0010);
    run_hs(2'd1);
    run_hs(2'd1);
    tick();
    chk_val("t3_pend_clear", bus.pend, 0);

    // T4: stale ack blocks the grant until it drops
    bus.sync_ack  = 1'b1;
    bus.req_pulse = 4'b0001;
    tick();
    bus.req_pulse = 4'b0000;
    chk_val("t4_pend", bus.pend, 4'b0001);
    repeat (3) tick();
    chk_val("t4_blocked_req", bus.sync_req, 0);
    chk_val("t4_blocked_busy", bus.busy, 0);
    bus.sync_ack = 1'b0;
    tick();
    chk_val("t4_grant_next", bus.sync_req, 1);
    chk_val("t4_grant_id", bus.sync_id, 0);
    run_hs(2'd0);

    // T5: async reset while in REQ, then fresh pulse on 3
    tick();
    bus.req_pulse = 4'b0100;
    tick();
    bus.req_pulse = 4'b0001;
    tick();
    bus.req_pulse = 4'b0000;
    chk_val("t5_in_req", bus.sync_req, 1);
    chk_val("t5_in_req_id", bus.sync_id, 2);
    rst = 1'b1;
    #1;
    chk_val("t5_rst_req", bus.sync_req, 0);
    chk_val("t5_rst_pend", bus.pend, 0);
    chk_val("t5_rst_busy", bus.busy, 0);
    #2;
    rst = 1'b0;
    tick();
    bus.req_pulse = 4'b1000;
    tick();
    bus.req_pulse = 4'b0000;
    chk_val("t5_pend3", bus.pend, 4'b1000);
    run_hs(2'd3);

`ifdef PCIE2_SYNC_ARB_TIMEOUT_EN
    // T6: no ack -> watchdog abort after 8 cycles in REQ
    begin
      int n;
      tick();
      bus.req_pulse = 4'b0010;
      tick();
      bus.req_pulse = 4'b0000;
      tick();
      chk_val("t6_grant", bus.sync_req, 1);
      n = 0;
      while (!bus.timeout_err && n < 30) begin
        tick();
        n++;
      end
      chk_val("t6_tmo_seen", bus.timeout_err, 1);
      chk_val("t6_tmo_cycles", n, 8);
      chk_val("t6_done_id", bus.done_id, 1);
      chk_val("t6_no_done", bus.done_pulse, 0);
      chk_val("t6_req_low", bus.sync_req, 0);
      tick();
      chk_val("t6_tmo_one_cycle", bus.timeout_err, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got running expected finished");
    $fatal(1, "bench timeout");
  end
endmodule
